// File: rtl/fetch_decode_pipe_reg_if.sv
// Handshake and data bundle between the fetch stage, the IF/ID register and decode.
// The master modport is the fetch/decode environment; the slave modport is the register.
interface fetch_decode_pipe_reg_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_add_in;
  logic [INSTR_W-1:0] instr_in;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_add_out;
  logic [INSTR_W-1:0] instr_out;
  logic               flush;
  logic [31:0]        stall_cnt;

  modport master (
    output in_valid, pc_add_in, instr_in, out_ready, flush,
    input  in_ready, out_valid, pc_add_out, instr_out, stall_cnt
  );

  modport slave (
    input  in_valid, pc_add_in, instr_in, out_ready, flush,
    output in_ready, out_valid, pc_add_out, instr_out, stall_cnt
  );
endinterface

// File: rtl/fetch_decode_pipe_reg.sv
// IF/ID pipeline register with a valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall-cycle counter enabled by defining FTD_STALL_CNT_EN.
module fetch_decode_pipe_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_decode_pipe_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_r, state_nx;
  logic [PC_W-1:0]    main_pc_r, main_pc_nx;
  logic [INSTR_W-1:0] main_instr_r, main_instr_nx;
  logic [PC_W-1:0]    skid_pc_r, skid_pc_nx;
  logic [INSTR_W-1:0] skid_instr_r, skid_instr_nx;
  logic               out_valid_r, in_ready_r;
  logic               in_fire_s, out_fire_s;

  // Handshakes use only registered readiness, so out_ready never reaches in_ready.
  assign in_fire_s  = bus.in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & bus.out_ready;

  // Next-state and next-data selection; flush overrides every transition.
  always_comb begin
    state_nx      = state_r;
    main_pc_nx    = main_pc_r;
    main_instr_nx = main_instr_r;
    skid_pc_nx    = skid_pc_r;
    skid_instr_nx = skid_instr_r;
    if (bus.flush) begin
      state_nx      = ST_EMPTY;
      main_pc_nx    = {PC_W{1'b0}};
      main_instr_nx = NOP_INSTR;
      skid_pc_nx    = {PC_W{1'b0}};
      skid_instr_nx = NOP_INSTR;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nx      = ST_ONE;
            main_pc_nx    = bus.pc_add_in;
            main_instr_nx = bus.instr_in;
          end else begin
            state_nx = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (out_fire_s && in_fire_s) begin
            state_nx      = ST_ONE;
            main_pc_nx    = bus.pc_add_in;
            main_instr_nx = bus.instr_in;
          end else if (out_fire_s) begin
            state_nx      = ST_EMPTY;
            main_pc_nx    = {PC_W{1'b0}};
            main_instr_nx = NOP_INSTR;
          end else if (in_fire_s) begin
            state_nx      = ST_TWO;
            skid_pc_nx    = bus.pc_add_in;
            skid_instr_nx = bus.instr_in;
          end else begin
            state_nx = ST_ONE;
          end
        end
        ST_TWO: begin
          // The skid beat is older than anything fetch can offer, so it moves up first.
          if (bus.out_ready) begin
            state_nx      = ST_ONE;
            main_pc_nx    = skid_pc_r;
            main_instr_nx = skid_instr_r;
            skid_pc_nx    = {PC_W{1'b0}};
            skid_instr_nx = NOP_INSTR;
          end else begin
            state_nx = ST_TWO;
          end
        end
        default: begin
          state_nx      = ST_EMPTY;
          main_pc_nx    = {PC_W{1'b0}};
          main_instr_nx = NOP_INSTR;
          skid_pc_nx    = {PC_W{1'b0}};
          skid_instr_nx = NOP_INSTR;
        end
      endcase
    end
  end

  // State, storage and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      main_pc_r    <= {PC_W{1'b0}};
      main_instr_r <= NOP_INSTR;
      skid_pc_r    <= {PC_W{1'b0}};
      skid_instr_r <= NOP_INSTR;
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_nx;
      main_pc_r    <= main_pc_nx;
      main_instr_r <= main_instr_nx;
      skid_pc_r    <= skid_pc_nx;
      skid_instr_r <= skid_instr_nx;
      out_valid_r  <= (state_nx != ST_EMPTY);
      in_ready_r   <= (state_nx != ST_TWO);
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.pc_add_out = main_pc_r;
  assign bus.instr_out  = main_instr_r;

`ifdef FTD_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where decode holds off a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (out_valid_r && !bus.out_ready && !bus.flush &&
                 (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule
